// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: writes received frames speculatively into a byte ring, commits or rolls back
// each one at frame end, and replays committed frames to a valid/ready byte consumer.
module rx_frame_ctrl #(
   parameter int AW      = 11,
   parameter int DAW     = 3,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        rxc,
   input  logic        rst_n,
   input  logic        link_up,
   input  logic [7:0]  data_in,
   input  logic        ena,
   input  logic        sof,
   input  logic        eof,
   input  logic        rx_err,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic [15:0] out_len,
   output logic [15:0] frm_ok_cnt,
   output logic [15:0] frm_drop_cnt,
   output logic        buf_ovf
);
   typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SHOW} r_state_t;

   localparam logic [AW:0]  DEPTH  = {1'b1, {AW{1'b0}}};
   localparam logic [DAW:0] DDEPTH = {1'b1, {DAW{1'b0}}};

   w_state_t    w_q, w_d;
   r_state_t    r_q, r_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d, cur_ptr;
   logic [15:0] len_q, len_d, cur_len, new_len, ok_q, ok_d, drop_q, drop_d;
   logic [15:0] olen_q, olen_d, idx_q, idx_d;
   logic [DAW:0] dwp_q, dwp_d, drp_q, drp_d;
   logic        bad_q, bad_d, cur_bad, new_bad, ovf_q, ovf_d;
   logic        opening, active, full, wr_en, ovr, good, push, pop;
   logic        valid_q, valid_d, last_q, last_d, accept, desc_full, desc_empty;
   logic [7:0]  mem [2**AW];
   logic [15:0] desc [2**DAW];
   logic [7:0]  rdata_q;

   assign desc_empty   = dwp_q == drp_q;
   assign desc_full    = (dwp_q - drp_q) == DDEPTH;
   assign accept       = valid_q & out_ready;
   assign out_data     = valid_q ? rdata_q : 8'd0;
   assign out_valid    = valid_q;
   assign out_last     = last_q;
   assign out_len      = olen_q;
   assign frm_ok_cnt   = ok_q;
   assign frm_drop_cnt = drop_q;
   assign buf_ovf      = ovf_q;

   // A SOF opens a frame on top of the committed pointer, which also discards any open frame.
   always_comb begin
      w_d      = w_q;
      wr_ptr_d = wr_ptr_q;
      wr_cmt_d = wr_cmt_q;
      len_d    = len_q;
      bad_d    = bad_q;
      ok_d     = ok_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      push     = 1'b0;
      opening  = link_up & sof & (w_q == W_IDLE | (w_q == W_RECV & !eof));
      active   = link_up & (w_q == W_RECV | opening);
      cur_ptr  = opening ? wr_cmt_q : wr_ptr_q;
      cur_len  = opening ? 16'd0 : len_q;
      cur_bad  = !opening & bad_q;
      full     = (cur_ptr - rd_ptr_q) == DEPTH;
      wr_en    = active & ena & !full & (cur_len != 16'(MAX_LEN));
      ovr      = active & ena & !wr_en;
      new_len  = cur_len + 16'(wr_en);
      new_bad  = cur_bad | (wr_en & rx_err);
      good     = !new_bad & !ovr & new_len >= 16'(MIN_LEN) & new_len <= 16'(MAX_LEN);
      if (w_q != W_IDLE & !link_up) begin
         wr_ptr_d = wr_cmt_q;
         drop_d   = drop_q + 16'd1;
         w_d      = W_IDLE;
      end else if (active) begin
         wr_ptr_d = cur_ptr + (AW+1)'(wr_en);
         len_d    = new_len;
         bad_d    = new_bad;
         drop_d   = drop_q + 16'(w_q == W_RECV & opening);
         w_d      = ovr ? W_DROP : W_RECV;
         if (eof) begin
            w_d  = W_IDLE;
            push = good & !desc_full;
            if (push) begin
               wr_cmt_d = wr_ptr_d;
               ok_d     = ok_q + 16'd1;
            end else begin
               wr_ptr_d = wr_cmt_q;
               drop_d   = drop_q + 16'd1;
               ovf_d    = ovf_q | ovr | (good & desc_full);
            end
         end
      end else if (w_q == W_DROP & eof) begin
         wr_ptr_d = wr_cmt_q;
         drop_d   = drop_q + 16'd1;
         ovf_d    = 1'b1;
         w_d      = W_IDLE;
      end
   end

   always_comb begin
      r_d      = r_q;
      rd_ptr_d = rd_ptr_q;
      olen_d   = olen_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      last_d   = last_q;
      pop      = 1'b0;
      if (r_q == R_IDLE & !desc_empty) begin
         r_d    = R_LOAD;
         olen_d = desc[drp_q[DAW-1:0]];
      end else if (r_q == R_LOAD) begin
         r_d     = R_SHOW;
         valid_d = 1'b1;
         idx_d   = 16'd1;
         last_d  = olen_q == 16'd1;
      end else if (r_q == R_SHOW & accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (last_q) begin
            pop     = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            r_d     = R_IDLE;
         end else begin
            idx_d  = idx_q + 16'd1;
            last_d = (idx_q + 16'd1) == olen_q;
         end
      end
      dwp_d = dwp_q + (DAW+1)'(push);
      drp_d = drp_q + (DAW+1)'(pop);
   end

   // Output byte is read at the address the pointer will hold, so it holds while stalled.
   always_ff @(posedge rxc) begin
      if (wr_en) mem[cur_ptr[AW-1:0]] <= data_in;
      if (push) desc[dwp_q[DAW-1:0]] <= new_len;
      rdata_q <= mem[rd_ptr_d[AW-1:0]];
   end

   always_ff @(posedge rxc or negedge rst_n) begin
      if (!rst_n) begin
         w_q      <= W_IDLE;
         r_q      <= R_IDLE;
         wr_ptr_q <= '0;
         wr_cmt_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         bad_q    <= 1'b0;
         ok_q     <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
         olen_q   <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         dwp_q    <= '0;
         drp_q    <= '0;
      end else begin
         w_q      <= w_d;
         r_q      <= r_d;
         wr_ptr_q <= wr_ptr_d;
         wr_cmt_q <= wr_cmt_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         bad_q    <= bad_d;
         ok_q     <= ok_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         olen_q   <= olen_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         dwp_q    <= dwp_d;
         drp_q    <= drp_d;
      end
   end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: table-driven, directed and randomized frames against a frame-level model.
module tb_rx_frame_ctrl;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;

   logic        clk = 1'b0, rst_n = 1'b0, link_up = 1'b1;
   logic        ena = 1'b0, sof = 1'b0, eof = 1'b0, rx_err = 1'b0, out_ready = 1'b0;
   logic [7:0]  data_in = 8'd0;
   logic [7:0]  out_data;
   logic        out_valid, out_last, buf_ovf;
   logic [15:0] out_len, frm_ok_cnt, frm_drop_cnt;

   rx_frame_ctrl dut (
      .rxc(clk), .rst_n(rst_n), .link_up(link_up), .data_in(data_in), .ena(ena),
      .sof(sof), .eof(eof), .rx_err(rx_err), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_len(out_len),
      .frm_ok_cnt(frm_ok_cnt), .frm_drop_cnt(frm_drop_cnt), .buf_ovf(buf_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         l;
      int         n;
   } ob_t;

   typedef struct {
      int len;
      int err_pos;
      int link_pos;
      bit commit;
      int ok;
      int drop;
      bit ovf;
   } vec_t;

   int  n_chk = 0, n_fail = 0, acc_cnt = 0;
   int  exp_ok = 0, exp_drop = 0;
   bit  exp_ovf = 0, rnd_rdy = 0, gap_need = 0;
   ob_t exp_q[$];
   ob_t e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = $urandom_range(9) < 7;
   endtask

   task automatic push_exp(input int len, input int base);
      for (int i = 0; i < len; i++) exp_q.push_back('{d: 8'(base + i), l: (i == len - 1), n: len});
   endtask

   task automatic chk_cnt(input string tag, input int ok, input int drop, input bit ovf);
      chk({tag, " ok_cnt"}, frm_ok_cnt, ok);
      chk({tag, " drop_cnt"}, frm_drop_cnt, drop);
      chk({tag, " buf_ovf"}, buf_ovf, ovf);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sof = 0; ena = 0; eof = 0; rx_err = 0;
      tick();
      tick();
      exp_q.delete();
      exp_ok = 0; exp_drop = 0; exp_ovf = 0;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_last", out_last, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_len", out_len, 0);
      chk_cnt("reset", 0, 0, 0);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(output int cyc);
      cyc = 0;
      while ((exp_q.size() != 0 || out_valid) && cyc < 5000) begin
         tick();
         cyc++;
      end
      repeat (3) tick();
      chk("drain done", exp_q.size(), 0);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!out_valid && t < 20) begin
         tick();
         t++;
      end
      chk("wait valid", out_valid, 1);
   endtask

   task automatic send_frame(input int len, input int err_pos, input int link_pos, input bit rnd, input int base);
      bit sof_first, eof_last;
      sof_first = rnd && len > 0 && $urandom_range(1) == 1;
      eof_last  = rnd && len > 0 && $urandom_range(1) == 1;
      if (!sof_first) begin
         sof = 1;
         tick();
         sof = 0;
      end
      for (int i = 0; i < len; i++) begin
         if (rnd) while ($urandom_range(3) == 0) tick();
         if (i == link_pos) begin
            link_up = 0;
            tick();
            link_up = 1;
         end
         sof = sof_first && i == 0;
         ena = 1;
         data_in = 8'(base + i);
         rx_err = (i == err_pos);
         eof = eof_last && i == len - 1;
         tick();
         sof = 0; ena = 0; eof = 0; rx_err = 0;
         if (rnd) begin
            data_in = 8'($urandom);
            rx_err = 1'($urandom_range(1));
         end
      end
      if (!eof_last) begin
         eof = 1;
         tick();
         eof = 0;
      end
      rx_err = 0;
   endtask

   // Every shown byte must match the head of the expected stream; stalls therefore check holding.
   always @(negedge clk) begin
      if (!rst_n) gap_need = 0;
      else begin
         if (gap_need) chk("gap after last", out_valid, 0);
         gap_need = 0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected byte: got data %0d, required no output", out_data);
            end else begin
               e = exp_q[0];
               chk("out data", out_data, e.d);
               chk("out last", out_last, e.l);
               chk("out len", out_len, e.n);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  acc_cnt++;
                  gap_need = out_last;
               end
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vec[8];
      int cyc, a0, len, err, lnk, base;
      bit commit;
      vec[0] = '{64, -1, -1, 1, 1, 0, 0};
      vec[1] = '{100, 49, -1, 0, 1, 1, 0};
      vec[2] = '{64, -1, -1, 1, 2, 1, 0};
      vec[3] = '{63, -1, -1, 0, 2, 2, 0};
      vec[4] = '{1519, -1, -1, 0, 2, 3, 1};
      vec[5] = '{1518, -1, -1, 1, 3, 3, 1};
      vec[6] = '{200, -1, 100, 0, 3, 4, 1};
      vec[7] = '{0, -1, -1, 0, 3, 5, 1};

      do_reset();

      // 64-byte frame held by the consumer: latency, holding, then drain
      out_ready = 0;
      send_frame(64, -1, -1, 0, 0);
      push_exp(64, 0);
      chk("latency push", out_valid, 0);
      tick();
      chk("latency +1", out_valid, 0);
      tick();
      chk("latency +2", out_valid, 1);
      repeat (3) tick();
      chk("stall data", out_data, 0);
      chk("stall len", out_len, 64);
      out_ready = 1;
      drain(cyc);
      chk_cnt("first", 1, 0, 0);

      do_reset();
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         send_frame(vec[i].len, vec[i].err_pos, vec[i].link_pos, 0, i * 17);
         if (vec[i].commit) push_exp(vec[i].len, i * 17);
         drain(cyc);
         chk_cnt($sformatf("vec%0d", i), vec[i].ok, vec[i].drop, vec[i].ovf);
      end

      // ring full: second max frame runs out of space
      do_reset();
      out_ready = 0;
      send_frame(1518, -1, -1, 0, 3);
      push_exp(1518, 3);
      send_frame(1518, -1, -1, 0, 9);
      chk_cnt("ring full", 1, 1, 1);
      out_ready = 1;
      drain(cyc);
      send_frame(1518, -1, -1, 0, 5);
      push_exp(1518, 5);
      drain(cyc);
      chk_cnt("after ring drain", 2, 1, 1);

      // descriptor FIFO full: ninth frame dropped, then eight frames stream out
      do_reset();
      out_ready = 0;
      for (int i = 0; i < 8; i++) begin
         send_frame(64, -1, -1, 0, i * 64);
         push_exp(64, i * 64);
      end
      send_frame(64, -1, -1, 0, 7);
      chk_cnt("desc full", 8, 1, 1);
      a0 = acc_cnt;
      out_ready = 1;
      drain(cyc);
      chk("desc drain bytes", acc_cnt - a0, 512);
      chk("desc drain fast", cyc <= 560, 1);

      // reset in the middle of a frame, then in the middle of a readout
      do_reset();
      out_ready = 1;
      sof = 1;
      tick();
      sof = 0;
      for (int i = 0; i < 30; i++) begin
         ena = 1;
         data_in = 8'(i);
         tick();
      end
      ena = 0;
      do_reset();
      send_frame(64, -1, -1, 0, 40);
      push_exp(64, 40);
      drain(cyc);
      chk_cnt("after frame reset", 1, 0, 0);
      out_ready = 0;
      send_frame(64, -1, -1, 0, 80);
      push_exp(64, 80);
      wait_valid();
      out_ready = 1;
      repeat (10) tick();
      out_ready = 0;
      do_reset();
      out_ready = 1;
      send_frame(64, -1, -1, 0, 120);
      push_exp(64, 120);
      drain(cyc);
      chk_cnt("after readout reset", 1, 0, 0);

      // random frames, each on an empty buffer, against the admission rules
      do_reset();
      rnd_rdy = 1;
      for (int k = 0; k < 25; k++) begin
         case ($urandom_range(9))
            0: len = $urandom_range(1530, 1519);
            1: len = $urandom_range(63, 0);
            default: len = $urandom_range(400, 64);
         endcase
         err  = (len > 0 && $urandom_range(4) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
         lnk  = (len >= 2 && len <= MAX_LEN && $urandom_range(7) == 0) ? int'($urandom_range(len - 1, 1)) : -1;
         base = $urandom_range(255);
         commit = lnk < 0 && err < 0 && len >= MIN_LEN && len <= MAX_LEN;
         send_frame(len, err, lnk, 1, base);
         if (commit) begin
            push_exp(len, base);
            exp_ok++;
         end else exp_drop++;
         if (lnk < 0 && len > MAX_LEN) exp_ovf = 1;
         drain(cyc);
         chk_cnt($sformatf("rnd%0d", k), exp_ok, exp_drop, exp_ovf);
      end
      rnd_rdy = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
